// File: rtl/int_ctrl.sv
// Priority-nesting interrupt controller: latches NUM_IRQ maskable sources plus one
// non-maskable arithmetic exception, and issues one registered call request at a time.
module int_ctrl #(
    parameter int unsigned          NUM_IRQ   = 8,
    parameter int unsigned          IDX_W     = 3,
    parameter logic [NUM_IRQ-1:0]   EDGE_MODE = {NUM_IRQ{1'b1}},
    parameter int unsigned          NEST      = 1,
    parameter logic [NUM_IRQ-1:0]   MASK_RST  = {NUM_IRQ{1'b1}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               exc,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_d,
    input  logic               int_ack,
    input  logic               reti,
    output logic               int_req,
    output logic               int_exc,
    output logic [IDX_W-1:0]   int_idx,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] in_service,
    output logic               exc_active
);

    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_in_service;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_irq_q;
    logic               r_exc_pend;
    logic               r_exc_active;
    logic               r_int_req;
    logic               r_int_exc;
    logic [IDX_W-1:0]   r_int_idx;

    logic [NUM_IRQ-1:0] w_pending_d;
    logic [NUM_IRQ-1:0] w_in_service_d;
    logic               w_exc_pend_d;
    logic               w_exc_active_d;
    logic               w_int_req_d;
    logic               w_int_exc_d;
    logic [IDX_W-1:0]   w_int_idx_d;

    logic               w_ack;
    logic               w_ack_exc;
    logic               w_ack_src;
    logic [NUM_IRQ-1:0] w_cand_vec;
    logic               w_cand_vld;
    logic [IDX_W-1:0]   w_cand_idx;
    logic [IDX_W-1:0]   w_is_idx;
    logic [NUM_IRQ-1:0] w_is_low;
    logic               w_issue_exc;
    logic               w_issue_src;

    // Ack only counts when a request is actually being displayed.
    assign w_ack      = int_ack & r_int_req;
    assign w_ack_exc  = w_ack & r_int_exc;
    assign w_ack_src  = w_ack & ~r_int_exc;
    assign w_cand_vec = r_pending & r_mask;

    // Lowest-index pending+enabled candidate and lowest in-service bit.
    always_comb begin
        w_cand_vld = 1'b0;
        w_cand_idx = '0;
        w_is_idx   = '0;
        w_is_low   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_cand_vec[i]) begin
                w_cand_vld = 1'b1;
                w_cand_idx = IDX_W'(i);
            end
            if (r_in_service[i]) begin
                w_is_idx = IDX_W'(i);
                w_is_low = '0;
                w_is_low[i] = 1'b1;
            end
        end
    end

    // Issue decision: exception first, then a source if no handler blocks it.
    always_comb begin
        w_issue_exc = r_exc_pend & ~r_exc_active;
        w_issue_src = 1'b0;
        if (!w_issue_exc && !r_exc_active && w_cand_vld) begin
            if (r_in_service == '0) begin
                w_issue_src = 1'b1;
            end else if ((NEST != 0) && (w_cand_idx < w_is_idx)) begin
                w_issue_src = 1'b1;
            end
        end
    end

    // Next-state for pending/exception/in-service and the registered request.
    always_comb begin
        w_pending_d    = r_pending;
        w_in_service_d = r_in_service;
        w_exc_active_d = r_exc_active;
        w_exc_pend_d   = exc | (r_exc_pend & ~w_ack_exc);
        w_int_req_d    = 1'b0;
        w_int_exc_d    = 1'b0;
        w_int_idx_d    = '0;

        for (int i = 0; i < NUM_IRQ; i++) begin
            if (EDGE_MODE[i]) begin
                // Set wins over ack-clear in the same cycle.
                w_pending_d[i] = (irq[i] & ~r_irq_q[i]) |
                                 (r_pending[i] & ~(w_ack_src && (r_int_idx == IDX_W'(i))));
            end else begin
                w_pending_d[i] = irq[i];
            end
        end

        // Retire the running handler before recording a newly acked one.
        if (reti) begin
            if (r_exc_active) begin
                w_exc_active_d = 1'b0;
            end else begin
                w_in_service_d = r_in_service & ~w_is_low;
            end
        end
        if (w_ack_exc) begin
            w_exc_active_d = 1'b1;
        end
        if (w_ack_src) begin
            w_in_service_d[r_int_idx] = 1'b1;
        end

        // One-cycle bubble after any ack so the new state is seen before re-issuing.
        if (!w_ack) begin
            if (w_issue_exc) begin
                w_int_req_d = 1'b1;
                w_int_exc_d = 1'b1;
            end else if (w_issue_src) begin
                w_int_req_d = 1'b1;
                w_int_idx_d = w_cand_idx;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pending    <= '0;
            r_in_service <= '0;
            r_mask       <= MASK_RST;
            r_irq_q      <= '0;
            r_exc_pend   <= 1'b0;
            r_exc_active <= 1'b0;
            r_int_req    <= 1'b0;
            r_int_exc    <= 1'b0;
            r_int_idx    <= '0;
        end else begin
            r_pending    <= w_pending_d;
            r_in_service <= w_in_service_d;
            r_irq_q      <= irq;
            r_exc_pend   <= w_exc_pend_d;
            r_exc_active <= w_exc_active_d;
            r_int_req    <= w_int_req_d;
            r_int_exc    <= w_int_exc_d;
            r_int_idx    <= w_int_idx_d;
            if (mask_we) begin
                r_mask <= mask_d;
            end
        end
    end

    assign int_req    = r_int_req;
    assign int_exc    = r_int_exc;
    assign int_idx    = r_int_idx;
    assign pending    = r_pending;
    assign in_service = r_in_service;
    assign exc_active = r_exc_active;

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Parametrised, priority-nesting interrupt controller for the single-cycle CPU. It latches up to NUM_IRQ external requests plus one non-maskable arithmetic exception (ALU overflow/underflow). It arbitrates these with lowest-index-wins priority and issues one registered call request at a time to the control unit, which answers with an acknowledge and later a return-from-interrupt. In-service tracking allows a higher-priority source to preempt a running handler, so selection no longer has to be recomputed combinationally from raw source/active bit vectors.

## Interface
- NUM_IRQ, 8, number of maskable sources; index 0 = highest priority
- IDX_W, 3, width of int_idx; must satisfy 2^IDX_W >= NUM_IRQ
- EDGE_MODE, {NUM_IRQ{1'b1}}, per-source mode: 1 = rising-edge latched, 0 = level
- NEST, 1, 1 = higher-priority source may preempt an active handler; 0 = one handler at a time
- MASK_RST, {NUM_IRQ{1'b1}}, mask register reset value (1 = enabled)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- irq  in  NUM_IRQ  source request lines
- exc  in  1  arithmetic exception (uflow | oflow); non-maskable, above irq[0]
- mask_we  in  1  load mask register from mask_d
- mask_d  in  NUM_IRQ  new mask value
- int_ack  in  1  control unit takes the current request this cycle
- reti  in  1  control unit executes return-from-interrupt this cycle
- int_req  out  1  registered call request
- int_exc  out  1  request is the exception (int_idx = 0 when set)
- int_idx  out  IDX_W  index of requested source
- pending  out  NUM_IRQ  pending register
- in_service  out  NUM_IRQ  in-service register
- exc_active  out  1  exception handler running

## Operation
- Reset (reset = 0 at a clock edge) sets pending, in_service, exc_pend, exc_active, irq_q, int_req, int_exc and int_idx to 0, and sets mask to MASK_RST.
- Pending update for edge sources: set on irq & ~irq_q. Clear when acknowledged. Set wins over clear in the same cycle.
- Pending update for level sources: pending[i] <= irq[i] every cycle. Ack does not clear it.
- exc_pend: set while exc = 1. Cleared on acknowledge of the exception; set wins.
- Candidate selection: the lowest i with pending[i] & mask[i]. Masked pending bits are held, not discarded.
- Issue conditions, evaluated each cycle. An exception is issued if exc_pend & ~exc_active. Otherwise a candidate is issued if exc_active = 0 and either:
  - in_service == 0, or
  - NEST = 1 and the candidate index is lower than the lowest set in_service bit.
- A source already in service is never re-issued until it is retired.
- int_req, int_exc and int_idx are registered from the issue decision. int_idx may change to a higher-priority source while int_req is high. The control unit uses the values present in the int_ack cycle.
- Acknowledge: int_ack & int_req commits the displayed request.
  - Exception: exc_active set, exc_pend cleared.
  - Source: in_service[int_idx] set, pending cleared (edge sources only).
  - int_req is forced 0 in the following cycle (one-cycle bubble), then re-evaluated.
- int_ack while int_req = 0 is ignored.
- reti clears exc_active if set; otherwise it clears the lowest set in_service bit. reti with nothing active is ignored.
- reti and int_ack in the same cycle: reti retires the current handler and ack records the new one. Both take effect at the same edge.
- mask_we: the new mask takes effect at the next edge. It never alters in_service or exc state.

## Timing
- irq edge sampled at edge E0: pending set at E0, int_req high after E1. Latency is 2 cycles from input to request.
- exc high at E0: exc_pend set at E0, int_req/int_exc high after E1.
- Ack at edge Ea: in_service updated at Ea, int_req low for cycle Ea..Ea+1. The next request appears no earlier than after Ea+1.
- reti at Er: bits cleared at Er. A newly eligible lower-priority request is visible after Er+1.
- A source held high through reset release sees irq_q = 0 and registers an edge at the first enabled clock.

## Test plan
- Single edge source: irq[3] pulses high (one cycle) → after 2 edges int_req=1, int_idx=3. Ack → pending[3]=0, in_service=8'h08, int_req=0 next cycle. reti → in_service=0, no re-request.
- Priority: irq[5] and irq[2] rise in the same cycle → int_idx=2 first. Ack + reti → then int_idx=5.
- Nesting, NEST=1: in_service=8'h10 (idx 4), irq[1] rises → int_req with idx 1, ack → in_service=8'h12. reti clears bit 1 first, then bit 4. With NEST=0 the same stimulus issues no request until in_service=0.
- Mask: mask_d=8'hFB written, irq[2] rises → pending[2]=1, int_req=0. Mask restored to 8'hFF → int_idx=2 after 1 cycle.
- Exception preemption: in_service=8'h01, exc high one cycle → int_exc=1, int_idx=0. Ack → exc_active=1. During exc_active, irq[0] level stays pending with no request. reti → exc_active=0 and in_service still 8'h01.
- Reset mid-operation: reset low with pending, in_service and int_req all nonzero → all registers 0 and mask=MASK_RST after that edge. Level irq[6] still high → int_req with idx 6 two edges after release.
